// File: rtl/led_bank_scheduler.sv
//==============================================================================
// Module   : led_bank_scheduler
// Purpose  : Round-robin time-sharing of the 8 led / 24 io_led bank between
//            NUM_REQ pattern sources, with minimum hold time and tick-paced
//            per-requester blinking. Optional macro: LED_LAMP_TEST_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module led_bank_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int TICK_DIV   = 50000000,
    parameter int HOLD_TICKS = 4,
    parameter int CNT_W      = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   pattern,
    input  logic [NUM_REQ-1:0]      blink,
`ifdef LED_LAMP_TEST_EN
    input  logic                    lamp_test,
`endif
    output logic [NUM_REQ-1:0]      grant,
    output logic [7:0]              led,
    output logic [23:0]             io_led,
    output logic                    busy
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_HANDOFF = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_last;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_phase;
    logic [NUM_REQ-1:0]  r_grant;
    logic [7:0]          r_led;
    logic [23:0]         r_io_led;
    logic                r_busy;

    logic                w_tick;
    logic                w_any;
    logic [IDX_W-1:0]    w_pick;
    logic [IDX_W-1:0]    w_idx;
    logic [31:0]         w_pick_pat;
    logic [31:0]         w_own_pat;
    logic                w_hold_done;
    logic                w_others;
    logic                w_release;

    // Free-running tick divider, independent of the FSM state.
    assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Scan downward so the last hit is the one closest after r_last.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDX_W'((int'(r_last) + k) % NUM_REQ);
            if (req[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_pick_pat  = pattern[32*int'(w_pick) +: 32];
    assign w_own_pat   = pattern[32*int'(r_owner) +: 32];
    assign w_hold_done = (r_hold == HOLD_W'(HOLD_TICKS));
    assign w_others    = |(req & ~r_grant);
    assign w_release   = !req[r_owner] || (w_hold_done && w_others);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_last   <= IDX_W'(NUM_REQ - 1);
            r_hold   <= '0;
            r_phase  <= 1'b1;
            r_grant  <= '0;
            r_led    <= 8'h00;
            r_io_led <= 24'h000000;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_OWN: begin
                    if (w_release) begin
                        r_state  <= ST_HANDOFF;
                        r_grant  <= '0;
                        r_led    <= 8'h00;
                        r_io_led <= 24'h000000;
                        r_busy   <= 1'b0;
                    end else begin
                        if (blink[r_owner] && !r_phase) begin
                            r_led    <= 8'h00;
                            r_io_led <= 24'h000000;
                        end else begin
                            r_led    <= w_own_pat[7:0];
                            r_io_led <= w_own_pat[31:8];
                        end
                        if (w_tick) begin
                            if (!w_hold_done) begin
                                r_hold <= r_hold + 1'b1;
                            end
                            r_phase <= blink[r_owner] ? ~r_phase : 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and HANDOFF both arbitrate; HANDOFF always lasts one cycle.
                    if (w_any) begin
                        r_state  <= ST_OWN;
                        r_owner  <= w_pick;
                        r_last   <= w_pick;
                        r_hold   <= '0;
                        r_phase  <= 1'b1;
                        r_grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                        r_led    <= w_pick_pat[7:0];
                        r_io_led <= w_pick_pat[31:8];
                        r_busy   <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_grant  <= '0;
                        r_led    <= 8'h00;
                        r_io_led <= 24'h000000;
                        r_busy   <= 1'b0;
                    end
                end
            endcase
`ifdef LED_LAMP_TEST_EN
            if (lamp_test) begin
                r_led    <= 8'hFF;
                r_io_led <= 24'hFFFFFF;
            end
`endif
        end
    end

    assign grant  = r_grant;
    assign led    = r_led;
    assign io_led = r_io_led;
    assign busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_led_bank_scheduler.sv
//==============================================================================
// Module   : tb_led_bank_scheduler
// Purpose  : Randomized and directed self-checking bench for led_bank_scheduler.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_led_bank_scheduler;

    localparam int NUM_REQ    = 3;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 2;
    localparam int CNT_W      = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] pattern;
    logic [NUM_REQ-1:0]    blink;
    logic [NUM_REQ-1:0]    grant;
    logic [7:0]            led;
    logic [23:0]           io_led;
    logic                  busy;

    logic [31:0] pat [NUM_REQ];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: owner index (-1 = nobody), last granted index.
    int m_owner;
    int m_last;
    int m_hold;
    int m_phase;
    int m_edges;
    logic [NUM_REQ-1:0] e_grant;
    logic [7:0]         e_led;
    logic [23:0]        e_io;

    always #5 clk = ~clk;

    always_comb begin
        pattern = '0;
        for (int i = 0; i < NUM_REQ; i++) pattern[32*i +: 32] = pat[i];
    end

    led_bank_scheduler #(
        .NUM_REQ(NUM_REQ), .TICK_DIV(TICK_DIV),
        .HOLD_TICKS(HOLD_TICKS), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .pattern(pattern), .blink(blink),
        .grant(grant), .led(led), .io_led(io_led), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_last  = NUM_REQ - 1;
        m_hold  = 0;
        m_phase = 1;
        m_edges = 0;
        e_grant = '0;
        e_led   = 8'h00;
        e_io    = 24'h000000;
    endfunction

    // One clock edge of the specified behaviour, using inputs present at that edge.
    function automatic void model_step();
        bit tick;
        int p;
        tick = ((m_edges % TICK_DIV) == TICK_DIV - 1);
        m_edges++;
        if (m_owner < 0) begin
            p = rr_pick(m_last, req);
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_hold  = 0;
                m_phase = 1;
                e_led   = pat[p][7:0];
                e_io    = pat[p][31:8];
            end else begin
                e_led = 8'h00;
                e_io  = 24'h000000;
            end
        end else begin
            logic [NUM_REQ-1:0] others;
            others = req;
            others[m_owner] = 1'b0;
            if (!req[m_owner] || (m_hold == HOLD_TICKS && others != 0)) begin
                m_owner = -1;
                e_led   = 8'h00;
                e_io    = 24'h000000;
            end else begin
                if (blink[m_owner] && m_phase == 0) begin
                    e_led = 8'h00;
                    e_io  = 24'h000000;
                end else begin
                    e_led = pat[m_owner][7:0];
                    e_io  = pat[m_owner][31:8];
                end
                if (tick) begin
                    if (m_hold < HOLD_TICKS) m_hold++;
                    m_phase = blink[m_owner] ? 1 - m_phase : 1;
                end
            end
        end
        e_grant = (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("grant",  32'(grant),  32'(e_grant));
        check("led",    32'(led),    32'(e_led));
        check("io_led", 32'(io_led), 32'(e_io));
        check("busy",   32'(busy),   32'(e_grant != '0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asserts reset mid-cycle and checks outputs clear without a clock edge.
    task automatic apply_reset(input logic [NUM_REQ-1:0] req_after);
        @(negedge clk);
        #2;
        req   = NUM_REQ'($urandom);
        rst_n = 1'b0;
        #1;
        check("rst_grant",  32'(grant),  32'h0);
        check("rst_led",    32'(led),    32'h0);
        check("rst_io_led", 32'(io_led), 32'h0);
        check("rst_busy",   32'(busy),   32'h0);
        @(negedge clk);
        req   = req_after;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        blink = '0;
        for (int i = 0; i < NUM_REQ; i++) pat[i] = $urandom;
        model_reset();
        #1;
        check("init_grant", 32'(grant), 32'h0);
        check("init_led",   32'(led),   32'h0);

        // Single owner, held past hold expiry.
        pat[0] = 32'hA5A5A53C;
        apply_reset(3'b001);
        cycle();
        check("single_grant", 32'(grant),  32'h1);
        check("single_led",   32'(led),    32'h3C);
        check("single_io",    32'(io_led), 32'hA5A5A5);
        check("single_busy",  32'(busy),   32'h1);
        run(20);
        check("single_held",  32'(grant),  32'h1);

        // Blink on requester 1.
        pat[1] = 32'hFFFFFFFF;
        blink  = 3'b010;
        apply_reset(3'b010);
        run(24);
        blink  = '0;

        // Preemption between requesters 0 and 2.
        apply_reset(3'b101);
        run(40);

        // Release mid-hold, then to IDLE.
        apply_reset(3'b101);
        run(3);
        check("rel_own0", 32'(grant), 32'h1);
        req = 3'b100;
        cycle();
        check("rel_handoff", 32'(grant), 32'h0);
        cycle();
        check("rel_own2", 32'(grant), 32'h4);
        run(3);

        // Async reset during OWN(2), then fresh priority from requester 0.
        apply_reset(3'b111);
        cycle();
        check("post_rst_grant", 32'(grant), 32'h1);
        req = 3'b000;
        run(3);
        check("idle_led", 32'(led), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) req = NUM_REQ'($urandom);
            if ($urandom_range(15) == 0) blink = NUM_REQ'($urandom);
            if ($urandom_range(31) == 0) pat[$urandom_range(NUM_REQ-1)] = $urandom;
            cycle();
            if (i == 1500) apply_reset(NUM_REQ'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
